// File: rtl/fma16_normround.sv
// -----------------------------------------------------------------------------
// fma16_normround
//   Back end of the fma16 datapath. Converts the unnormalised signed-magnitude
//   sum from the add stage into a rounded binary16 result with exception flags.
//   Two registered stages with a valid/ready handshake on both sides:
//     stage 1: leading-one detect, normalising/denormalising shift
//     stage 2: rounding, re-normalisation, overflow/zero handling, packing
//
// Ports
//   clk        in   clock
//   reset_n    in   synchronous active-low reset
//   in_valid   in   upstream sum valid
//   in_ready   out  block can accept this cycle (combinational from out_ready)
//   Sm         in   [33:0] sum magnitude, unsigned
//   Se         in   [6:0]  sum exponent, two's complement
//   Ss         in   sum sign
//   sticky_in  in   OR of bits already discarded upstream
//   rm         in   [1:0] 00 RZ, 01 RNE, 10 RDN, 11 RUP
//   out_valid  out  result valid
//   out_ready  in   downstream accepts
//   result     out  [15:0] binary16 result
//   flags      out  [2:0]  {overflow, underflow, inexact}
// -----------------------------------------------------------------------------
module fma16_normround #(
    parameter int BIAS = 15,
    parameter int LEAD = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [33:0] Sm,
    input  logic [6:0]  Se,
    input  logic        Ss,
    input  logic        sticky_in,
    input  logic [1:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [2:0]  flags
);

    localparam int EMAX = 2 * BIAS + 1;   // first biased exponent that overflows

    localparam logic [1:0] RM_RZ  = 2'b00;
    localparam logic [1:0] RM_RNE = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s2_ready;

    assign s2_ready = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_ready;

    // ------------------------------------------------------------------
    // Stage 1: leading-one detect and shift
    // ------------------------------------------------------------------
    logic [5:0]        lod_k;
    logic signed [8:0] e_pre;
    logic              tiny_d;
    logic [8:0]        rsh;
    logic [33:0]       norm;
    logic [67:0]       ext;
    logic [10:0]       sig_d;
    logic              g_d;
    logic              s_d;
    logic [7:0]        e_d;

    always_comb begin
        lod_k = '0;
        for (int i = 0; i < 34; i++) begin
            if (Sm[i]) lod_k = 6'(i);
        end
    end

    // Biased exponent of the normalised value; 9 bits so that extreme Se
    // combined with any k can neither wrap nor alias a valid exponent.
    assign e_pre = $signed({{2{Se[6]}}, Se}) + $signed({3'b000, lod_k})
                 - $signed(9'(LEAD));

    always_comb begin
        tiny_d = (e_pre <= 9'sd0);
        rsh    = tiny_d ? 9'(9'sd1 - e_pre) : 9'd0;
        norm   = Sm << (6'd33 - lod_k);
        // Low 34 bits of ext catch whatever the denormalising shift pushes out.
        ext    = {norm, 34'b0} >> rsh[5:0];
        if (rsh >= 9'd34) begin
            sig_d = '0;
            g_d   = 1'b0;
            s_d   = (|Sm) | sticky_in;
        end else begin
            sig_d = ext[67:57];
            g_d   = ext[56];
            s_d   = (|ext[55:0]) | sticky_in;
        end
        e_d = tiny_d ? 8'd0 : e_pre[7:0];
    end

    logic [10:0] sig_q;
    logic        g_q;
    logic        s_q;
    logic [7:0]  e_q;
    logic        sign_q;
    logic [1:0]  rm_q;
    logic        zero_q;
    logic        tiny_q;

    // ------------------------------------------------------------------
    // Stage 2: round, re-normalise, pack
    // ------------------------------------------------------------------
    logic        inexact;
    logic        round_up;
    logic [11:0] sum12;
    logic [7:0]  e_f;
    logic [9:0]  frac;
    logic        ovf_to_inf;
    logic [15:0] result_d;
    logic [2:0]  flags_d;

    always_comb begin
        inexact = g_q | s_q;
        case (rm_q)
            RM_RZ:   round_up = 1'b0;
            RM_RNE:  round_up = g_q & (s_q | sig_q[0]);
            RM_RDN:  round_up = sign_q & inexact;
            default: round_up = ~sign_q & inexact;
        endcase

        sum12 = {1'b0, sig_q} + 12'(round_up);
        if (sum12[11]) begin
            // 0x7FF + 1: significand wraps to 1.000, exponent steps up
            e_f  = e_q + 8'd1;
            frac = '0;
        end else if ((e_q == 8'd0) && sum12[10]) begin
            // subnormal rounded up into the smallest normal
            e_f  = 8'd1;
            frac = sum12[9:0];
        end else begin
            e_f  = e_q;
            frac = sum12[9:0];
        end

        ovf_to_inf = (rm_q == RM_RNE) || ((rm_q == RM_RUP) && !sign_q)
                  || ((rm_q == RM_RDN) && sign_q);

        result_d = '0;
        flags_d  = '0;
        if (zero_q) begin
            if (!s_q) begin
                result_d = (rm_q == RM_RDN) ? 16'h8000 : 16'h0000;
                flags_d  = 3'b000;
            end else begin
                // nonzero magnitude below the smallest subnormal
                result_d = ((rm_q == RM_RUP) && !sign_q) ? 16'h0001 : {sign_q, 15'h0000};
                flags_d  = 3'b011;
            end
        end else if (e_f >= 8'(EMAX)) begin
            result_d = {sign_q, ovf_to_inf ? 15'h7C00 : 15'h7BFF};
            flags_d  = 3'b101;
        end else begin
            result_d = {sign_q, e_f[4:0], frac};
            flags_d  = {1'b0, tiny_q & inexact, inexact};
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [15:0] result_q;
    logic [2:0]  flags_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q <= result_d;
                    flags_q  <= flags_d;
                end
            end
        end
    end

    // Stage-1 payload needs no reset; it is qualified by s1_valid_q.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            sig_q  <= sig_d;
            g_q    <= g_d;
            s_q    <= s_d;
            e_q    <= e_d;
            sign_q <= Ss;
            rm_q   <= rm;
            zero_q <= (Sm == 34'd0);
            tiny_q <= tiny_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fma16_normround.sv
module tb_fma16_normround;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] Sm;
    logic [6:0]  Se;
    logic        Ss;
    logic        sticky_in;
    logic [1:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    fma16_normround dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sm        (Sm),
        .Se        (Se),
        .Ss        (Ss),
        .sticky_in (sticky_in),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [18:0] sb_q[$];
    logic [18:0] cur_exp;
    logic        stall_prev = 1'b0;
    logic [18:0] stall_val;
    int          tog_mode = 0;   // 0 ready high, 1 pattern 1,0,0,1, 2 random, 3 ready low
    int          ph = 0;
    logic [3:0]  pat = 4'b1001;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: scale the exact value into units of the result quantum,
    // round the integer, then read the encoding straight off that integer.
    function automatic logic [18:0] model(input logic [33:0] sm, input logic [6:0] se,
                                          input logic ss, input logic st, input logic [1:0] r);
        int           e_in, msb, eb, ec, sh, d;
        logic [127:0] w, n, rem, half;
        logic         above, tie, inexact, up, tiny, inf;
        longint       enc;
        logic [15:0]  res;
        logic [2:0]   fl;
        e_in = int'($signed(se));
        if (sm == 34'd0) begin
            if (!st) return {(r == 2'b10) ? 16'h8000 : 16'h0000, 3'b000};
            return {((r == 2'b11) && !ss) ? 16'h0001 : {ss, 15'h0000}, 3'b011};
        end
        msb = 0;
        for (int i = 0; i < 34; i++) if (sm[i]) msb = i;
        eb   = e_in + msb - 30;
        ec   = (eb < 1) ? 1 : eb;
        tiny = (eb <= 0);
        sh   = e_in - 20 - ec;
        w    = 128'(sm);
        if (sh >= 0) begin
            n = w << sh; above = 1'b0; tie = 1'b0; inexact = st;
        end else begin
            d       = -sh;
            n       = w >> d;
            rem     = w & ((128'd1 << d) - 128'd1);
            half    = 128'd1 << (d - 1);
            above   = (rem > half) || ((rem == half) && st);
            tie     = (rem == half) && !st;
            inexact = (rem != 128'd0) || st;
        end
        case (r)
            2'b00:   up = 1'b0;
            2'b01:   up = above | (tie & n[0]);
            2'b10:   up = ss & inexact;
            default: up = ~ss & inexact;
        endcase
        enc = longint'(ec - 1) * 1024 + longint'(n[63:0]) + longint'({63'b0, up});
        if (enc >= 64'sd31744) begin
            inf = (r == 2'b01) || ((r == 2'b11) && !ss) || ((r == 2'b10) && ss);
            res = {ss, inf ? 15'h7C00 : 15'h7BFF};
            fl  = 3'b101;
        end else begin
            res = {ss, enc[14:0]};
            fl  = {1'b0, tiny & inexact, inexact};
        end
        return {res, fl};
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tog_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = pat[ph]; ph = (ph + 1) % 4; end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [18:0] e;
        logic        exp_ir;
        if (!reset_n) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            exp_ir = !((sb_q.size() == 2) && !out_ready);
            check("in_ready", 32'(in_ready), 32'(exp_ir));
            if (stall_prev && out_valid)
                check("stall_hold", 32'({result, flags}), 32'(stall_val));
            stall_prev = out_valid && !out_ready;
            stall_val  = {result, flags};
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 32'(result), 32'(e[18:3]));
                    check("flags", 32'(flags), 32'(e[2:0]));
                end
            end
            if (in_valid && in_ready) sb_q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [33:0] sm, input logic [6:0] se, input logic ss,
                        input logic st, input logic [1:0] r,
                        input logic use_exp, input logic [18:0] exp_v);
        logic ok;
        Sm = sm; Se = se; Ss = ss; sticky_in = st; rm = r;
        cur_exp  = use_exp ? exp_v : model(sm, se, ss, st, r);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [63:0] r64;
        logic [33:0] sm;
        logic [6:0]  se;
        int          msb, lo;
        r64 = {$urandom(), $urandom()};
        msb = $urandom_range(0, 33);
        sm  = r64[33:0] >> (33 - msb);
        sm[msb] = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            lo = $urandom_range(0, msb);
            sm = sm & ~((34'd1 << lo) - 34'd1);
        end
        if ($urandom_range(0, 15) == 0) sm = 34'd0;
        if ($urandom_range(0, 1) == 1) se = 7'($urandom_range(0, 40));
        else se = 7'($urandom_range(0, 127));
        send(sm, se, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'b0, 19'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(posedge clk);
        check("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    localparam logic [1:0] RZ = 2'b00, RNE = 2'b01, RDN = 2'b10, RUP = 2'b11;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; Sm = '0; Se = '0; Ss = 1'b0;
        sticky_in = 1'b0; rm = RNE; cur_exp = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // latency of the first transfer
        send(34'h040000000, 7'd15, 1'b0, 1'b0, RNE, 1'b1, {16'h3C00, 3'b000});
        @(negedge clk); check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        send(34'h0C0000000, 7'd15, 1'b0, 1'b0, RNE, 1'b1, {16'h4200, 3'b000});
        send(34'h040080000, 7'd15, 1'b0, 1'b0, RNE, 1'b1, {16'h3C00, 3'b001});
        send(34'h040080000, 7'd15, 1'b0, 1'b1, RNE, 1'b1, {16'h3C01, 3'b001});
        send(34'h040080000, 7'd15, 1'b0, 1'b1, RZ,  1'b1, {16'h3C00, 3'b001});
        send(34'h040000000, 7'd31, 1'b0, 1'b0, RNE, 1'b1, {16'h7C00, 3'b101});
        send(34'h040000000, 7'd31, 1'b0, 1'b0, RZ,  1'b1, {16'h7BFF, 3'b101});
        send(34'h040000000, 7'd31, 1'b1, 1'b0, RUP, 1'b1, {16'hFBFF, 3'b101});
        send(34'h040000000, 7'd0,  1'b0, 1'b0, RNE, 1'b1, {16'h0200, 3'b000});
        send(34'h040000001, 7'h6C, 1'b0, 1'b0, RUP, 1'b1, {16'h0001, 3'b011});
        send(34'h000000000, 7'd9,  1'b0, 1'b0, RDN, 1'b1, {16'h8000, 3'b000});
        send(34'h000000000, 7'd9,  1'b0, 1'b1, RUP, 1'b1, {16'h0001, 3'b011});
        send(34'h000000000, 7'd9,  1'b1, 1'b1, RZ,  1'b1, {16'h8000, 3'b011});
        send(34'h0FFF00000, 7'd15, 1'b0, 1'b0, RNE, 1'b1, {16'h4400, 3'b001});
        wait_drain();

        // back-to-back stream with out_ready 1,0,0,1
        tog_mode = 1;
        for (int i = 0; i < 8; i++) send_rand();
        wait_drain();
        tog_mode = 0;

        // reset with two results in flight
        tog_mode = 3;
        @(posedge clk); #1;
        send(34'h040000000, 7'd15, 1'b0, 1'b0, RNE, 1'b1, {16'h3C00, 3'b000});
        send(34'h0C0000000, 7'd15, 1'b0, 1'b0, RNE, 1'b1, {16'h4200, 3'b000});
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        tog_mode  = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(34'h040000000, 7'd0, 1'b0, 1'b0, RNE, 1'b1, {16'h0200, 3'b000});
        @(negedge clk); check("post_rst_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk); check("post_rst_cycle2_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        wait_drain();

        // randomized traffic with random backpressure
        tog_mode = 2;
        for (int i = 0; i < 400; i++) send_rand();
        wait_drain();
        tog_mode = 0;
        for (int i = 0; i < 100; i++) send_rand();
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
